// File: rtl/ahbl_sram_ws.sv
// AHB-Lite SRAM slave with programmable wait states and a two-cycle error response.
// Serves cache line fills and spills; read data is registered on entry to the final data-phase cycle.
module ahbl_sram_ws #(
    parameter int unsigned W_ADDR    = 32,
    parameter int unsigned W_DATA    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned WAIT_NSEQ = 1,
    parameter int unsigned WAIT_SEQ  = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ahbls_hready_resp,
    input  logic              ahbls_hready,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [W_DATA-1:0] ahbls_hwdata,
    output logic [W_DATA-1:0] ahbls_hrdata
);

    localparam int unsigned W_BYTES = W_DATA / 8;
    localparam int unsigned OFF_W   = $clog2(W_BYTES);
    localparam int unsigned IDX_W   = W_ADDR - OFF_W;
    localparam int unsigned MEM_AW  = $clog2(DEPTH);
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                hready_q;
    logic                hresp_q;
    logic [W_DATA-1:0]   hrdata_q;
    logic [MEM_AW-1:0]   idx_q;
    logic [OFF_W-1:0]    off_q;
    logic [2:0]          size_q;
    logic                write_q;

    logic [W_DATA-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    a_idx_c;
    logic                a_bad_c;
    logic [CNT_W-1:0]    a_wait_c;
    logic                accept_c;
    logic [MEM_AW-1:0]   rd_idx_c;
    logic [W_BYTES-1:0]  be_c;
    logic [W_DATA-1:0]   wr_word_c;
    logic                wr_en_c;
    logic [W_DATA-1:0]   rd_word_c;
    logic                unused_c;

    assign unused_c = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock};

    // Address-phase decode: word index, legality and wait count of the incoming transfer
    always_comb begin
        a_idx_c  = ahbls_haddr[W_ADDR-1:OFF_W];
        a_bad_c  = ({1'b0, a_idx_c} >= (IDX_W+1)'(DEPTH)) ||
                   ((32'd8 << ahbls_hsize) > 32'(W_DATA));
        a_wait_c = ahbls_htrans[0] ? CNT_W'(WAIT_SEQ) : CNT_W'(WAIT_NSEQ);
        accept_c = ahbls_hready && ahbls_htrans[1] &&
                   ((state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2));
    end

    // Byte-lane merge for the write completing in this LAST cycle
    always_comb begin
        be_c      = '0;
        wr_word_c = mem[idx_q];
        for (int unsigned b = 0; b < W_BYTES; b++) begin
            be_c[b] = (b >= 32'(off_q)) && (b < 32'(off_q) + (32'd1 << size_q));
            if (be_c[b]) begin
                wr_word_c[8*b +: 8] = ahbls_hwdata[8*b +: 8];
            end
        end
        wr_en_c = (state_q == ST_LAST) && write_q;
    end

    // Read source: forward the merged word when a read enters LAST as a write to it retires
    always_comb begin
        rd_idx_c = (state_q == ST_WAIT) ? idx_q : a_idx_c[MEM_AW-1:0];
        if (wr_en_c && (rd_idx_c == idx_q)) begin
            rd_word_c = wr_word_c;
        end else begin
            rd_word_c = mem[rd_idx_c];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[idx_q] <= wr_word_c;
        end
    end

    // Data-phase FSM with registered ready/response/read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q  <= ST_LAST;
                        cnt_q    <= '0;
                        hready_q <= 1'b1;
                        hrdata_q <= rd_word_c;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                end
                default: begin
                    if (accept_c) begin
                        idx_q   <= a_idx_c[MEM_AW-1:0];
                        off_q   <= ahbls_haddr[OFF_W-1:0];
                        size_q  <= ahbls_hsize;
                        write_q <= ahbls_hwrite;
                        if (a_bad_c) begin
                            state_q  <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b1;
                        end else if (a_wait_c != '0) begin
                            state_q  <= ST_WAIT;
                            cnt_q    <= a_wait_c;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b0;
                        end else begin
                            state_q  <= ST_LAST;
                            hready_q <= 1'b1;
                            hresp_q  <= 1'b0;
                            hrdata_q <= rd_word_c;
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign ahbls_hready_resp = hready_q;
    assign ahbls_hresp       = hresp_q;
    assign ahbls_hrdata      = hrdata_q;

endmodule

// File: tb/tb_ahbl_sram_ws.sv
// Bench for ahbl_sram_ws: pipelined AHB-Lite master driving directed and random transfers
// against a word-array model that predicts data-phase length, response and read data.
module tb_ahbl_sram_ws;

    localparam int unsigned WN    = 2;
    localparam int unsigned WS    = 0;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ahbls_hready_resp;
    logic        ahbls_hready;
    logic        ahbls_hresp;
    logic [31:0] ahbls_haddr = '0;
    logic        ahbls_hwrite = 1'b0;
    logic [1:0]  ahbls_htrans = 2'b00;
    logic [2:0]  ahbls_hsize = 3'd2;
    logic [2:0]  ahbls_hburst = 3'd0;
    logic [3:0]  ahbls_hprot = 4'd0;
    logic        ahbls_hmastlock = 1'b0;
    logic [31:0] ahbls_hwdata = '0;
    logic [31:0] ahbls_hrdata;

    always #5 clk = ~clk;
    assign ahbls_hready = ahbls_hready_resp;

    ahbl_sram_ws #(
        .W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH), .WAIT_NSEQ(WN), .WAIT_SEQ(WS)
    ) dut (
        .clk(clk), .rst(rst),
        .ahbls_hready_resp(ahbls_hready_resp), .ahbls_hready(ahbls_hready),
        .ahbls_hresp(ahbls_hresp), .ahbls_haddr(ahbls_haddr),
        .ahbls_hwrite(ahbls_hwrite), .ahbls_htrans(ahbls_htrans),
        .ahbls_hsize(ahbls_hsize), .ahbls_hburst(ahbls_hburst),
        .ahbls_hprot(ahbls_hprot), .ahbls_hmastlock(ahbls_hmastlock),
        .ahbls_hwdata(ahbls_hwdata), .ahbls_hrdata(ahbls_hrdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       q[$];
    logic [31:0] mdl [DEPTH];
    int          vec  = 0;
    int          errs = 0;
    logic [31:0] last_rd   = '0;
    logic [31:0] last_mask = '0;
    bit          last_ok   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input xfer_t t);
        return ((t.addr >> 2) >= DEPTH) || ((32'd8 << t.size) > 32'd32);
    endfunction

    function automatic int exp_cyc(input xfer_t t);
        if (is_bad(t)) return 2;
        return (t.trans[0] ? int'(WS) : int'(WN)) + 1;
    endfunction

    function automatic logic [31:0] lane_mask(input xfer_t t);
        logic [31:0] m  = '0;
        int          nb = 1 << t.size;
        int          of = int'(t.addr[1:0]);
        for (int b = 0; b < 4; b++) begin
            if (b >= of && b < of + nb) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic push(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [1:0] trans, input logic [31:0] wdata);
        xfer_t t;
        t.addr = addr; t.wr = wr; t.size = size; t.trans = trans; t.wdata = wdata;
        q.push_back(t);
    endtask

    task automatic drive_addr(input bit valid, input xfer_t t);
        ahbls_hburst    = 3'($urandom);
        ahbls_hprot     = 4'($urandom);
        ahbls_hmastlock = 1'($urandom);
        if (valid) begin
            ahbls_haddr = t.addr; ahbls_hwrite = t.wr;
            ahbls_hsize = t.size; ahbls_htrans = t.trans;
        end else begin
            ahbls_htrans = 2'b00;
        end
    endtask

    // Completion of one data phase: length, response, read data and model update
    task automatic finish_beat(input xfer_t t, input int cyc);
        int          idx = int'(t.addr >> 2);
        logic [31:0] m   = lane_mask(t);
        check("cycles", 32'(cyc), 32'(exp_cyc(t)));
        if (is_bad(t)) begin
            if (last_ok) check("err_hrdata_hold", ahbls_hrdata & last_mask, last_rd & last_mask);
        end else if (!t.wr) begin
            check("rdata", ahbls_hrdata & m, mdl[idx] & m);
            last_rd = mdl[idx]; last_mask = m; last_ok = 1'b1;
        end else begin
            mdl[idx] = (mdl[idx] & ~m) | (t.wdata & m);
            last_ok  = 1'b0;
        end
    endtask

    // Run the queue as a pipelined master; called at posedge+1
    task automatic run_q();
        int    n = q.size();
        int    a = 0;
        int    d = -1;
        int    dcyc = 0;
        int    budget = 0;
        bit    rdy;
        xfer_t nil;
        nil = '{default: '0};
        drive_addr(n > 0, (n > 0) ? q[0] : nil);
        while (!(a >= n && d < 0)) begin
            if (budget++ > 4 * n + 10) begin
                vec++; errs++;
                $error("FAIL run_timeout: observed %0d cycles expected <= %0d", budget, 4 * n + 10);
                break;
            end
            @(negedge clk);
            rdy = ahbls_hready_resp;
            if (d >= 0) begin
                dcyc++;
                check("hresp", 32'(ahbls_hresp), 32'(is_bad(q[d])));
                if (rdy) finish_beat(q[d], dcyc);
            end else begin
                check("idle_resp", {30'd0, rdy, ahbls_hresp}, 32'b10);
            end
            @(posedge clk); #1;
            if (rdy) begin
                d = (a < n && q[a].trans[1]) ? a : -1;
                if (a < n) a++;
                dcyc = 0;
                if (d >= 0) ahbls_hwdata = q[d].wdata;
                drive_addr(a < n, (a < n) ? q[a] : nil);
            end
        end
        drive_addr(1'b0, nil);
        q.delete();
    endtask

    initial begin
        xfer_t t;
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_resp", {30'd0, ahbls_hready_resp, ahbls_hresp}, 32'b10);
        check("rst_hrdata", ahbls_hrdata, 32'h0);
        last_rd = '0; last_mask = '1; last_ok = 1'b1;
        @(posedge clk); #1;

        // fill the array so every later read has a defined value
        for (int i = 0; i < int'(DEPTH); i++)
            push(32'(i * 4), 1'b1, 3'd2, (i == 0) ? 2'b10 : 2'b11, $urandom);
        run_q();

        // NSEQ word write then read
        push(32'h10, 1'b1, 3'd2, 2'b10, 32'hDEADBEEF);
        push(32'h10, 1'b0, 3'd2, 2'b10, 32'h0);
        run_q();
        check("wr_rd_word", ahbls_hrdata, 32'hDEADBEEF);

        // INCR4 read after preloading 1..4
        for (int i = 0; i < 4; i++) push(32'(32'h40 + 4 * i), 1'b1, 3'd2, 2'b10, 32'(i + 1));
        for (int i = 0; i < 4; i++) push(32'(32'h40 + 4 * i), 1'b0, 3'd2, (i == 0) ? 2'b10 : 2'b11, 32'h0);
        run_q();
        check("incr4_last", ahbls_hrdata, 32'd4);

        // byte write into a word, then halfword and word reads
        push(32'h20, 1'b1, 3'd2, 2'b10, 32'h11223344);
        push(32'h22, 1'b1, 3'd0, 2'b10, 32'h00AA0000);
        push(32'h22, 1'b0, 3'd1, 2'b10, 32'h0);
        run_q();
        check("half_upper", {16'h0, ahbls_hrdata[31:16]}, 32'h11AA);
        push(32'h20, 1'b0, 3'd2, 2'b10, 32'h0);
        run_q();
        check("merged_word", ahbls_hrdata, 32'h11AA3344);

        // out-of-range and oversize transfers error out and change nothing
        push(32'(DEPTH * 4), 1'b0, 3'd2, 2'b10, 32'h0);
        push(32'(DEPTH * 4), 1'b1, 3'd2, 2'b10, 32'hFFFFFFFF);
        push(32'h0, 1'b1, 3'd3, 2'b10, 32'hFFFFFFFF);
        push(32'h0, 1'b0, 3'd2, 2'b10, 32'h0);
        run_q();
        check("bad_no_write", ahbls_hrdata, mdl[0]);

        // zero-wait write then read of the same word
        push(32'h8, 1'b1, 3'd2, 2'b11, 32'hA5A55A5A);
        push(32'h8, 1'b0, 3'd2, 2'b11, 32'h0);
        run_q();
        check("bypass", ahbls_hrdata, 32'hA5A55A5A);

        // reset during the wait of a write drops it
        push(32'h30, 1'b1, 3'd2, 2'b10, 32'h12345678);
        run_q();
        t.addr = 32'h30; t.wr = 1'b1; t.size = 3'd2; t.trans = 2'b10; t.wdata = '0;
        drive_addr(1'b1, t);
        @(posedge clk); #1;
        drive_addr(1'b0, t);
        ahbls_hwdata = 32'hCAFEF00D;
        @(negedge clk);
        check("wait_stall", {31'd0, ahbls_hready_resp}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_resp", {30'd0, ahbls_hready_resp, ahbls_hresp}, 32'b10);
        check("midrst_hrdata", ahbls_hrdata, 32'h0);
        last_rd = '0; last_mask = '1; last_ok = 1'b1;
        @(posedge clk); #1;
        push(32'h30, 1'b0, 3'd2, 2'b10, 32'h0);
        run_q();
        check("dropped_write", ahbls_hrdata, 32'h12345678);

        // random mix of sizes, directions, transfer types and bad addresses
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 40; i++) begin
                int          kind = int'($urandom_range(0, 9));
                int          idx  = int'($urandom_range(0, DEPTH + 3));
                logic [2:0]  sz   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                logic [1:0]  tr   = (kind < 4) ? 2'b10 : (kind < 8) ? 2'b11 : (kind == 8) ? 2'b00 : 2'b01;
                int          off  = (sz == 3'd0) ? int'($urandom_range(0, 3)) :
                                    (sz == 3'd1) ? 2 * int'($urandom_range(0, 1)) : 0;
                push(32'(idx * 4 + off), 1'($urandom), sz, tr, $urandom);
            end
            run_q();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
